// File: rtl/prefetch.sv
// Buffered instruction fetch stage: a DEPTH-entry prefetch queue between the instruction bus
// and decode, with wait-state/fault handling and flush on trap/mret/branch redirects.
module prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branch_vector,
  input  logic        trap,
  input  logic        mret,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  input  logic        stall,
  input  logic        invalidate,
  output logic [31:0] fetch_address,
  output logic        fetch_request,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_error,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        fault_out,
  output logic        valid_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [31:0]       q_pc [DEPTH];
  logic [31:0]       q_instr [DEPTH];
  logic              q_fault [DEPTH];
  logic [31:0]       pc_q, pc_d, next_pc_q, next_pc_d, instr_q, instr_d;
  logic              fault_q, fault_d, valid_q, valid_d;

  logic              redirect, completion, push, pop;
  logic [31:0]       redirect_vector, resp_instr;

  assign redirect        = trap | mret | branch;
  assign redirect_vector = trap ? trap_vector : (mret ? mret_vector : branch_vector);
  assign fetch_request   = (state_q == StRun) && (count_q < Full);
  assign fetch_address   = fetch_pc_q;
  assign completion      = fetch_request && fetch_ready;
  assign resp_instr      = fetch_error ? 32'h0 : fetch_data;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    valid_d    = valid_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect) begin
      // Flush: any completion in this cycle belongs to the abandoned path.
      state_d    = StRun;
      fetch_pc_d = redirect_vector;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      valid_d    = 1'b0;
    end else begin
      if (completion) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        push       = 1'b1;
        if (fetch_error) state_d = StHalt;
      end
      if (!stall) begin
        if (invalidate) begin
          valid_d = 1'b0;
        end else if (count_q != '0) begin
          pc_d      = q_pc[rd_ptr_q];
          next_pc_d = q_pc[rd_ptr_q] + 32'd4;
          instr_d   = q_instr[rd_ptr_q];
          fault_d   = q_fault[rd_ptr_q];
          valid_d   = 1'b1;
          pop       = 1'b1;
        end else if (completion) begin
          // Empty queue: hand the response straight to decode.
          pc_d      = fetch_pc_q;
          next_pc_d = fetch_pc_q + 32'd4;
          instr_d   = resp_instr;
          fault_d   = fetch_error;
          valid_d   = 1'b1;
          push      = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_VECTOR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_q       <= '0;
      next_pc_q  <= '0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_fault[i] <= 1'b0;
      end
    end else if (push) begin
      q_pc[wr_ptr_q]    <= fetch_pc_q;
      q_instr[wr_ptr_q] <= resp_instr;
      q_fault[wr_ptr_q] <= fetch_error;
    end
  end

  assign pc_out          = pc_q;
  assign next_pc_out     = next_pc_q;
  assign instruction_out = instr_q;
  assign fault_out       = fault_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_prefetch.sv
// Directed bench for prefetch: a per-cycle vector table from reset, then hand-written
// sequences for wait states, redirects over a full queue, fetch faults and async reset.
module tb_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch, trap, mret, stall, invalidate, fetch_ready, fetch_error;
  logic [31:0] branch_vector, trap_vector, mret_vector;
  logic [31:0] fetch_address, fetch_data, pc_out, next_pc_out, instruction_out;
  logic        fetch_request, fault_out, valid_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Bus memory model: each word is the bitwise inverse of its address.
  assign fetch_data = ~fetch_address;

  prefetch #(.RESET_VECTOR(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .branch         (branch),
    .branch_vector  (branch_vector),
    .trap           (trap),
    .mret           (mret),
    .trap_vector    (trap_vector),
    .mret_vector    (mret_vector),
    .stall          (stall),
    .invalidate     (invalidate),
    .fetch_address  (fetch_address),
    .fetch_request  (fetch_request),
    .fetch_ready    (fetch_ready),
    .fetch_data     (fetch_data),
    .fetch_error    (fetch_error),
    .pc_out         (pc_out),
    .next_pc_out    (next_pc_out),
    .instruction_out(instruction_out),
    .fault_out      (fault_out),
    .valid_out      (valid_out)
  );

  typedef struct {
    logic        stall, inv, rdy, err, br, trp, mrt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(input logic s, input logic i, input logic r, input logic e,
                              input logic b, input logic t, input logic m, input logic rq,
                              input logic [31:0] a, input logic v, input logic [31:0] p,
                              input logic f);
    vec_t x;
    x.stall = s; x.inv = i; x.rdy = r; x.err = e; x.br = b; x.trp = t; x.mrt = m;
    x.exp_req = rq; x.exp_addr = a; x.exp_valid = v; x.exp_pc = p; x.exp_fault = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; invalidate = 0; fetch_ready = 0; fetch_error = 0;
    branch = 0; trap = 0; mret = 0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] pc, input logic fault);
    chk({name, " valid"}, {31'h0, valid_out}, 32'h1);
    chk({name, " pc"}, pc_out, pc);
    chk({name, " next_pc"}, next_pc_out, pc + 32'd4);
    chk({name, " instr"}, instruction_out, fault ? 32'h0 : ~pc);
    chk({name, " fault"}, {31'h0, fault_out}, {31'h0, fault});
  endtask

  // Fill three queue entries under stall, then release stall in the same cycle as a
  // completion and a redirect: the response must be dropped and fetch restart at vec.
  task automatic redirect_over_queue(input logic with_trap, input logic [31:0] vec);
    clear_inputs();
    stall = 1; fetch_ready = 1;
    repeat (3) step();
    stall = 0; branch = 1; trap = with_trap;
    chk("rdq req_during_redirect", {31'h0, fetch_request}, 32'h1);
    step();
    chk("rdq valid_after_redirect", {31'h0, valid_out}, 32'h0);
    branch = 0; trap = 0;
    chk("rdq addr_after_redirect", fetch_address, vec);
    step();
    chk_out("rdq first", vec, 1'b0);
  endtask

  initial begin
    branch_vector = 32'h100; trap_vector = 32'h200; mret_vector = 32'h300;
    clear_inputs();
    reset = 1;
    //                stall inv rdy err br trp mrt req  addr   valid pc     fault
    vecs[0]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h000, 1, 32'h000, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h004, 1, 32'h004, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h008, 1, 32'h008, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 32'h00C, 1, 32'h008, 0);
    vecs[4]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 32'h010, 1, 32'h008, 0);
    vecs[5]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 32'h014, 1, 32'h008, 0);
    vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 32'h018, 1, 32'h008, 0);
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 32'h01C, 1, 32'h008, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h01C, 1, 32'h00C, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h01C, 1, 32'h010, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h020, 1, 32'h014, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h020, 1, 32'h018, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h020, 1, 32'h01C, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h020, 0, 32'h000, 0);
    vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 1, 32'h020, 0, 32'h000, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h024, 1, 32'h020, 0);
    vecs[16] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h024, 1, 32'h024, 0);
    vecs[17] = mk(0, 0, 1, 0, 1, 0, 0, 1, 32'h028, 0, 32'h000, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h100, 1, 32'h100, 0);
    vecs[19] = mk(0, 0, 1, 1, 0, 0, 0, 1, 32'h104, 1, 32'h104, 1);
    vecs[20] = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h108, 0, 32'h000, 0);
    vecs[21] = mk(0, 0, 1, 0, 1, 0, 1, 0, 32'h108, 0, 32'h000, 0);
    vecs[22] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h300, 1, 32'h300, 0);
    vecs[23] = mk(0, 0, 1, 0, 0, 1, 1, 1, 32'h304, 0, 32'h000, 0);
    vecs[24] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h200, 1, 32'h200, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", {31'h0, valid_out}, 32'h0);
    chk("reset fault", {31'h0, fault_out}, 32'h0);
    chk("reset pc", pc_out, 32'h0);
    chk("reset next_pc", next_pc_out, 32'h0);
    chk("reset instr", instruction_out, 32'h0);
    chk("reset req", {31'h0, fetch_request}, 32'h1);
    chk("reset addr", fetch_address, 32'h0);
    reset = 0;

    for (int k = 0; k < 25; k++) begin
      stall = vecs[k].stall; invalidate = vecs[k].inv; fetch_ready = vecs[k].rdy;
      fetch_error = vecs[k].err; branch = vecs[k].br; trap = vecs[k].trp; mret = vecs[k].mrt;
      chk($sformatf("vec%0d req", k), {31'h0, fetch_request}, {31'h0, vecs[k].exp_req});
      chk($sformatf("vec%0d addr", k), fetch_address, vecs[k].exp_addr);
      step();
      if (vecs[k].exp_valid) chk_out($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_fault);
      else chk($sformatf("vec%0d valid", k), {31'h0, valid_out}, 32'h0);
    end

    // Wait states: ready every third cycle, continuing from 0x204.
    clear_inputs();
    for (int i = 0; i < 9; i++) begin
      fetch_ready = (i % 3 == 2);
      step();
      chk($sformatf("slow%0d valid", i), {31'h0, valid_out}, {31'h0, fetch_ready});
      if (fetch_ready) chk($sformatf("slow%0d pc", i), pc_out, 32'h204 + 32'(4 * (i / 3)));
    end

    redirect_over_queue(1'b0, 32'h100);
    redirect_over_queue(1'b1, 32'h200);

    // Async reset between edges while valid_out is high.
    clear_inputs();
    fetch_ready = 1;
    #2;
    reset = 1;
    #1;
    chk("areset valid", {31'h0, valid_out}, 32'h0);
    chk("areset addr", fetch_address, 32'h0);
    chk("areset req", {31'h0, fetch_request}, 32'h1);
    #4;
    reset = 0;
    step();
    chk_out("after_reset", 32'h0, 1'b0);

    // Fetch fault at 0x8 halts fetching until a trap.
    step();
    fetch_error = 1;
    chk("err addr", fetch_address, 32'h8);
    step();
    fetch_error = 0;
    chk_out("err", 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt%0d req", i), {31'h0, fetch_request}, 32'h0);
      step();
      chk($sformatf("halt%0d valid", i), {31'h0, valid_out}, 32'h0);
    end
    trap = 1;
    chk("halt trap req", {31'h0, fetch_request}, 32'h0);
    step();
    trap = 0;
    chk("resume req", {31'h0, fetch_request}, 32'h1);
    chk("resume addr", fetch_address, 32'h200);
    step();
    chk_out("resume", 32'h200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch.md
# prefetch

Buffered instruction fetch stage: successor to the single-register fetch path. Decouples the instruction bus from decode with a parametrised DEPTH-entry prefetch queue, supports a variable-latency bus with wait states and fetch-error reporting, and flushes on trap/mret/branch redirects. Sits between busio (instruction port) and decode. Presents the same redirect and hazard inputs and decode outputs as the existing fetch stage, plus fault_out.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- branch / branch_vector  in  1 / 32  redirect from memory stage
- trap / mret  in  1 / 1  redirects from writeback
- trap_vector / mret_vector  in  32 / 32  from csr
- stall  in  1  hazard: hold output register
- invalidate  in  1  hazard: emit bubble, do not consume queue
- fetch_address  out  32  instruction bus address (= fetch_pc)
- fetch_request  out  1  bus request
- fetch_ready  in  1  transaction completes this cycle; fetch_data/fetch_error valid
- fetch_data  in  32  instruction word
- fetch_error  in  1  bus fault on this completion
- pc_out / next_pc_out  out  32 / 32  address of instruction, address + 4
- instruction_out  out  32  instruction word (0 on fault)
- fault_out  out  1  fetch faulted at pc_out
- valid_out  out  1  output register holds a live instruction

## Operation
- State: fetch_pc, queue (DEPTH × {pc, instr, fault}), rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH, log2 DEPTH + 1 bits), FSM {RUN, HALT}, output registers.
- Redirect = trap | mret | branch; priority trap > mret > branch. On redirect edge: fetch_pc ← selected vector, queue flushed (count 0, pointers 0), FSM ← RUN, valid_out ← 0 regardless of stall, any completion that cycle discarded.
- fetch_request = (FSM == RUN) && (count < DEPTH); combinational, not gated by redirect inputs. fetch_address = fetch_pc.
- Completion = fetch_request && fetch_ready. Bus is abortable: no hold requirement on address/request between cycles.
- Completion without redirect: fetch_pc ← fetch_pc + 4 (mod 2^32); entry {fetch_pc, fetch_error ? 0 : fetch_data, fetch_error} is pushed or bypassed; if fetch_error, FSM ← HALT.
- HALT: no requests until redirect or reset.
- Output update, no redirect, stall = 0:
  - invalidate = 1: valid_out ← 0; no pop.
  - count > 0: load head, pop; valid_out ← 1.
  - count = 0 and completion: bypass entry directly to outputs, no push; valid_out ← 1.
  - otherwise valid_out ← 0.
- stall = 1: outputs hold; completions push to queue.
- Push and pop in one cycle: count unchanged. count never exceeds DEPTH (no request when full).
- next_pc_out = pc_out + 4, computed at load.

## Timing
- Reset values: valid_out 0, fault_out 0, pc_out / next_pc_out / instruction_out 0, count 0, FSM RUN, fetch_pc RESET_VECTOR, so fetch_request = 1.
- Response-to-valid_out latency: 1 cycle on the bypass path; queued entries issue 1 per unstalled cycle.
- Zero-wait-state bus, no stalls: one instruction per cycle, back-to-back.
- Redirect: first fetch from new vector in cycle after redirect edge; earliest valid_out at the edge after that completes (≥2 edges after redirect).
- Reset asserted mid-operation: outputs and queue clear asynchronously; resumes from RESET_VECTOR on first edge after deassert.

## Test plan
- Reset release, fetch_ready=1, stall=0: fetch_address 0,4,8…; valid_out rises one edge after first completion with pc_out=0, next_pc_out=4; then one pc per cycle with no bubbles.
- stall=1 for 6 cycles, DEPTH=4, ready=1: exactly 4 pushes, then fetch_request=0; on release pc_out steps through consecutive addresses, 1 per cycle, no gap, and fetch_request reasserts.
- fetch_ready every third cycle: valid_out pulses once per completion, pc_out sequential, no duplicate or dropped pc.
- 3 entries queued plus completion in the same cycle as branch=1, vector 0x100 (and a second run with trap=1, branch=1, trap_vector 0x200): response discarded, valid_out=0 next cycle, next valid pc_out = 0x100 (resp. 0x200).
- fetch_error on pc 0x8: fault_out=1, pc_out=0x8, instruction_out=0; fetch_request stays 0 until trap to 0x200, then fetching resumes at 0x200.
- reset asserted between clock edges with valid_out=1: valid_out and count go to 0 before the next edge.
